kmeans_iter_ctrl: RTL and testbench

- Iteration sequencer for the k-means operator datapath. It sits between the host/config registers, the memory fetch and write engines, and the k-means module.
- Issues the one-time centroid read, then one tuple-set read per iteration.
- Pulses start/done to the operator and counts updated-centroid cachelines to close each iteration.
- Reports iteration progress and a sticky protocol-error flag.

---
 rtl/kmeans_iter_ctrl_pkg.sv | 25 ++
 rtl/kmeans_iter_ctrl.sv | 138 +++++++++++++
 tb/tb_kmeans_iter_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_iter_ctrl_pkg.sv
// kmeans_iter_ctrl_pkg: shared widths and the FSM state encoding for the k-means iteration sequencer.
// Revision: 1.0
`default_nettype none

package kmeans_iter_ctrl_pkg;

  localparam int NUM_CLUSTER_BITS  = 4;
  localparam int MAX_DEPTH_BITS    = 9;
  localparam int NUM_ITER_BITS     = 16;
  localparam int CL_CNT_BITS       = 32;
  localparam int WORDS_PER_CL_LOG2 = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_REQ_CENT = 3'd2,
    ST_REQ_TUPLE = 3'd3,
    ST_WAIT_UPD = 3'd4,
    ST_NEXT     = 3'd5,
    ST_FINISH   = 3'd6
  } kmeans_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/kmeans_iter_ctrl.sv
// kmeans_iter_ctrl: issues the centroid read and per-iteration tuple reads, and closes
// each iteration by counting updated-centroid cachelines. Revision: 1.0
`default_nettype none

module kmeans_iter_ctrl
  import kmeans_iter_ctrl_pkg::*;
#(
  parameter int NUM_ITER_BITS = kmeans_iter_ctrl_pkg::NUM_ITER_BITS,
  parameter int CL_CNT_BITS   = kmeans_iter_ctrl_pkg::CL_CNT_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_ITER_BITS-1:0]    cfg_num_iter,
  input  logic [NUM_CLUSTER_BITS:0]   cfg_num_cluster,
  input  logic [MAX_DEPTH_BITS:0]     cfg_data_dim,
  input  logic [CL_CNT_BITS-1:0]      cfg_tuple_cl,
  output logic                        rd_req_valid,
  input  logic                        rd_req_ready,
  output logic                        rd_req_sel,
  output logic [CL_CNT_BITS-1:0]      rd_req_len,
  output logic                        start_operator,
  output logic                        um_done,
  input  logic                        updated_centroid_valid,
  input  logic                        updated_centroid_last,
  output logic [NUM_ITER_BITS-1:0]    iter_cnt,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  // One spare bit above the full product so the round-up addition cannot wrap.
  localparam int PROD_W = NUM_CLUSTER_BITS + MAX_DEPTH_BITS + 3;

  kmeans_ctrl_state_t r_state, w_next;

  logic [NUM_ITER_BITS-1:0]  r_num_iter, r_iter_cnt, w_iter_target;
  logic [NUM_CLUSTER_BITS:0] r_num_cluster;
  logic [MAX_DEPTH_BITS:0]   r_data_dim;
  logic [CL_CNT_BITS-1:0]    r_tuple_cl, r_cent_cl, r_cl_cnt;
  logic                      r_done, r_err;
  logic [PROD_W-1:0]         w_prod, w_prod_rnd;

  assign w_prod        = PROD_W'(r_num_cluster) * PROD_W'(r_data_dim);
  assign w_prod_rnd    = w_prod + PROD_W'((1 << WORDS_PER_CL_LOG2) - 1);
  assign w_iter_target = (r_num_iter == '0) ? NUM_ITER_BITS'(1) : r_num_iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    rd_req_valid   = 1'b0;
    rd_req_sel     = 1'b0;
    rd_req_len     = '0;
    start_operator = 1'b0;
    um_done        = 1'b0;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_LATCH;
      ST_LATCH: begin
        start_operator = 1'b1;
        w_next         = ST_REQ_CENT;
      end
      ST_REQ_CENT: begin
        rd_req_valid = 1'b1;
        rd_req_len   = r_cent_cl;
        if (rd_req_ready) w_next = ST_REQ_TUPLE;
      end
      ST_REQ_TUPLE: begin
        rd_req_valid = 1'b1;
        rd_req_sel   = 1'b1;
        rd_req_len   = r_tuple_cl;
        if (rd_req_ready) w_next = ST_WAIT_UPD;
      end
      ST_WAIT_UPD:  if (updated_centroid_valid && updated_centroid_last) w_next = ST_NEXT;
      // Later iterations reuse centroids from the operator's internal loop, so no centroid re-read.
      ST_NEXT:      w_next = (r_iter_cnt == w_iter_target) ? ST_FINISH : ST_REQ_TUPLE;
      ST_FINISH: begin
        um_done = 1'b1;
        w_next  = ST_IDLE;
      end
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_iter    <= '0;
      r_num_cluster <= '0;
      r_data_dim    <= '0;
      r_tuple_cl    <= '0;
      r_cent_cl     <= '0;
      r_cl_cnt      <= '0;
      r_iter_cnt    <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_num_iter    <= cfg_num_iter;
        r_num_cluster <= cfg_num_cluster;
        r_data_dim    <= cfg_data_dim;
        r_tuple_cl    <= cfg_tuple_cl;
        r_cl_cnt      <= '0;
        r_iter_cnt    <= '0;
        r_done        <= 1'b0;
        r_err         <= 1'b0;
      end
      if (r_state == ST_LATCH) begin
        r_cent_cl <= CL_CNT_BITS'(w_prod_rnd >> WORDS_PER_CL_LOG2);
      end
      if (r_state == ST_WAIT_UPD && updated_centroid_valid) begin
        if (updated_centroid_last) begin
          if ((r_cl_cnt + CL_CNT_BITS'(1)) != r_cent_cl) r_err <= 1'b1;
          r_cl_cnt   <= '0;
          r_iter_cnt <= r_iter_cnt + NUM_ITER_BITS'(1);
        end else begin
          r_cl_cnt <= r_cl_cnt + CL_CNT_BITS'(1);
        end
      end else if (updated_centroid_valid) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_FINISH) r_done <= 1'b1;
    end
  end

  assign iter_cnt = r_iter_cnt;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_kmeans_iter_ctrl.sv
// tb_kmeans_iter_ctrl: directed-vector bench for the k-means iteration sequencer.
// Revision: 1.0
`default_nettype none

module tb_kmeans_iter_ctrl;
  import kmeans_iter_ctrl_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       start = 1'b0;
  logic [NUM_ITER_BITS-1:0]   cfg_num_iter = '0;
  logic [NUM_CLUSTER_BITS:0]  cfg_num_cluster = '0;
  logic [MAX_DEPTH_BITS:0]    cfg_data_dim = '0;
  logic [CL_CNT_BITS-1:0]     cfg_tuple_cl = '0;
  logic                       rd_req_valid;
  logic                       rd_req_ready = 1'b1;
  logic                       rd_req_sel;
  logic [CL_CNT_BITS-1:0]     rd_req_len;
  logic                       start_operator;
  logic                       um_done;
  logic                       updated_centroid_valid = 1'b0;
  logic                       updated_centroid_last = 1'b0;
  logic [NUM_ITER_BITS-1:0]   iter_cnt;
  logic                       busy;
  logic                       done;
  logic                       err;

  kmeans_iter_ctrl dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .cfg_num_iter           (cfg_num_iter),
    .cfg_num_cluster        (cfg_num_cluster),
    .cfg_data_dim           (cfg_data_dim),
    .cfg_tuple_cl           (cfg_tuple_cl),
    .rd_req_valid           (rd_req_valid),
    .rd_req_ready           (rd_req_ready),
    .rd_req_sel             (rd_req_sel),
    .rd_req_len             (rd_req_len),
    .start_operator         (start_operator),
    .um_done                (um_done),
    .updated_centroid_valid (updated_centroid_valid),
    .updated_centroid_last  (updated_centroid_last),
    .iter_cnt               (iter_cnt),
    .busy                   (busy),
    .done                   (done),
    .err                    (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int n_sop, n_umd, n_cent, n_tup;
  int cyc = 0;
  int last_cyc = 0;
  logic req_sel_q[$];
  int   req_len_q[$];
  int   gaps[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (start_operator) n_sop = n_sop + 1;
    if (um_done) n_umd = n_umd + 1;
    if (rd_req_valid && rd_req_ready) begin
      req_sel_q.push_back(rd_req_sel);
      req_len_q.push_back(int'(rd_req_len));
      if (rd_req_sel) begin
        n_tup = n_tup + 1;
        gaps.push_back(cyc - last_cyc);
      end else begin
        n_cent = n_cent + 1;
      end
    end
    if (updated_centroid_valid && updated_centroid_last) last_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    n_sop = 0; n_umd = 0; n_cent = 0; n_tup = 0;
    req_sel_q.delete();
    req_len_q.delete();
    gaps.delete();
  endtask

  task automatic do_start(input int niter, input int ncl, input int dim, input int tcl);
    @(negedge clk);
    cfg_num_iter    = NUM_ITER_BITS'(niter);
    cfg_num_cluster = (NUM_CLUSTER_BITS+1)'(ncl);
    cfg_data_dim    = (MAX_DEPTH_BITS+1)'(dim);
    cfg_tuple_cl    = CL_CNT_BITS'(tcl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tuples(input int n);
    int t = 0;
    while (n_tup < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("tuple_req_wait", 64'(n_tup), 64'(n));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic send_updates(input int n);
    for (int i = 0; i < n; i++) begin
      updated_centroid_valid = 1'b1;
      updated_centroid_last  = (i == n - 1);
      @(negedge clk);
    end
    updated_centroid_valid = 1'b0;
    updated_centroid_last  = 1'b0;
  endtask

  initial begin
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_outputs", {62'(rd_req_valid), busy, start_operator},  64'd0);
    chk("rst_status",  {44'(iter_cnt), done, err, um_done},        64'd0);
    rst_n = 1'b1;

    // Single iteration, 4 clusters x 8 dims -> 2 centroid cachelines.
    rd_req_ready = 1'b1;
    clear_log();
    do_start(1, 4, 8, 100);
    chk("t1_sop_level", {62'(start_operator), busy}, {62'd1, 1'b1});
    wait_tuples(1);
    send_updates(2);
    wait_idle();
    chk("t1_sop_cnt", 64'(n_sop), 64'd1);
    chk("t1_req0", {32'(req_sel_q[0]), 32'(req_len_q[0])}, {32'd0, 32'd2});
    chk("t1_req1", {32'(req_sel_q[1]), 32'(req_len_q[1])}, {32'd1, 32'd100});
    chk("t1_umd_cnt", 64'(n_umd), 64'd1);
    chk("t1_final", {61'(iter_cnt), done, err}, {61'd1, 1'b1, 1'b0});

    // Three iterations: one centroid read, three tuple reads.
    clear_log();
    do_start(3, 4, 8, 100);
    chk("t2_done_clr", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      wait_tuples(i + 1);
      send_updates(2);
      chk("t2_iter_cnt", 64'(iter_cnt), 64'(i + 1));
      if (i < 2) chk("t2_no_early_umd", 64'(n_umd), 64'd0);
    end
    wait_idle();
    chk("t2_counts", {16'(n_cent), 16'(n_tup), 16'(n_umd), 16'(n_sop)},
        {16'd1, 16'd3, 16'd1, 16'd1});
    chk("t2_gap2", 64'(gaps[1]), 64'd2);
    chk("t2_gap3", 64'(gaps[2]), 64'd2);
    chk("t2_final", {61'(iter_cnt), done, err}, {61'd3, 1'b1, 1'b0});

    // Fetch engine stalls the centroid request for 10 cycles.
    clear_log();
    rd_req_ready = 1'b0;
    do_start(1, 3, 7, 9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_stall_req", {30'(rd_req_valid), rd_req_sel, rd_req_len},
          {30'd1, 1'b0, 32'd2});
    end
    chk("t3_no_advance", {32'(n_cent), 32'(n_tup)}, 64'd0);
    rd_req_ready = 1'b1;
    wait_tuples(1);
    chk("t3_tuple_len", 64'(req_len_q[1]), 64'd9);
    send_updates(2);
    wait_idle();
    chk("t3_final", {61'(iter_cnt), done, err}, {61'd1, 1'b1, 1'b0});

    // Three update lines where two are expected: sticky error.
    clear_log();
    do_start(1, 4, 8, 100);
    wait_tuples(1);
    send_updates(3);
    chk("t4_err_set", 64'(err), 64'd1);
    wait_idle();
    chk("t4_err_sticky", {62'(err), done}, {62'd1, 1'b1});

    // Start pulse and config changes during WAIT_UPD are ignored.
    clear_log();
    do_start(2, 4, 8, 100);
    @(negedge clk);
    chk("t5_err_clr", 64'(err), 64'd0);
    wait_tuples(1);
    cfg_tuple_cl = 32'd50;
    cfg_num_iter = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_updates(2);
    wait_tuples(2);
    chk("t5_len_kept", 64'(req_len_q[2]), 64'd100);
    send_updates(2);
    wait_idle();
    chk("t5_final", {61'(iter_cnt), done, err}, {61'd2, 1'b1, 1'b0});
    chk("t5_one_job", {32'(n_sop), 32'(n_cent)}, {32'd1, 32'd1});

    // Stray update outside WAIT_UPD.
    @(negedge clk);
    updated_centroid_valid = 1'b1;
    @(negedge clk);
    updated_centroid_valid = 1'b0;
    chk("t5_stray_err", 64'(err), 64'd1);

    // Asynchronous reset while the tuple request is pending.
    clear_log();
    rd_req_ready = 1'b0;
    do_start(1, 4, 8, 100);
    @(negedge clk);
    rd_req_ready = 1'b1;
    @(negedge clk);
    rd_req_ready = 1'b0;
    chk("t6_tuple_pending", {62'(rd_req_valid), rd_req_sel}, {62'd1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", {61'(rd_req_valid), busy, start_operator}, 64'd0);
    chk("t6_async_status", {61'(done), err, um_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_req_ready = 1'b1;
    clear_log();
    do_start(0, 4, 8, 100);
    wait_tuples(1);
    chk("t6_first_req", {32'(req_sel_q[0]), 32'(req_len_q[0])}, {32'd0, 32'd2});
    send_updates(2);
    wait_idle();
    chk("t6_final", {61'(iter_cnt), done, err}, {61'd1, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
